// File: rtl/demux1t4_stream_pkg.sv
// Shared constants and helpers for the 1-to-4 stream demultiplexer.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    // Occupancy counter width: must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/demux1t4_stream_if.sv
// Producer-side stream and four consumer-side channels of the demultiplexer.
interface demux1t4_stream_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
);
    import demux_pkg::*;

    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0]       I;
    logic [SEL_W-1:0]       S;
    logic                   I_valid;
    logic                   I_ready;
    logic [WIDTH-1:0]       O0;
    logic [WIDTH-1:0]       O1;
    logic [WIDTH-1:0]       O2;
    logic [WIDTH-1:0]       O3;
    logic [NUM_CH-1:0]      O_valid;
    logic [NUM_CH-1:0]      O_ready;
    logic [NUM_CH*CW-1:0]   O_count;

    // Environment side: drives the input stream and the consumer readies.
    modport master (
        output I, S, I_valid, O_ready,
        input  I_ready, O0, O1, O2, O3, O_valid, O_count
    );

    // Demultiplexer side.
    modport slave (
        input  I, S, I_valid, O_ready,
        output I_ready, O0, O1, O2, O3, O_valid, O_count
    );

endinterface

// File: rtl/demux1t4_stream_chan_fifo.sv
// Per-channel FIFO: registered head, full/empty flags and occupancy count.
module chan_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          head,
    output logic                      full,
    output logic                      empty,
    output logic [cnt_w(DEPTH)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        full_q, full_d;
    logic                        empty_q, empty_d;
    logic                        push_ok, pop_ok;

    // Next-state: a full FIFO never accepts, even when popping the same cycle.
    always_comb begin
        push_ok  = push && !full_q;
        pop_ok   = pop && !empty_q;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // State registers; storage is cleared too so the head reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/demux1t4_stream.sv
// Registered 1-to-4 stream demultiplexer: one FIFO per channel, select decode on top.
module demux1t4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    demux1t4_stream_if.slave   bus
);
    localparam int CW = cnt_w(DEPTH);

    logic [NUM_CH-1:0]            push;
    logic [NUM_CH-1:0]            full;
    logic [NUM_CH-1:0]            empty;
    logic [NUM_CH-1:0][WIDTH-1:0] head;
    logic [NUM_CH-1:0][CW-1:0]    count;

    // Ready only looks at the addressed channel, so a stalled channel blocks only its own words.
    assign bus.I_ready = !rst && !full[bus.S];

    // Steer an accepted word to the FIFO picked by S.
    always_comb begin
        push = '0;
        if (bus.I_valid && bus.I_ready) begin
            push[bus.S] = 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[k]),
            .pop   (bus.O_ready[k]),
            .din   (bus.I),
            .head  (head[k]),
            .full  (full[k]),
            .empty (empty[k]),
            .count (count[k])
        );
    end

    assign bus.O_valid = ~empty;
    assign bus.O_count = count;
    assign bus.O0      = head[0];
    assign bus.O1      = head[1];
    assign bus.O2      = head[2];
    assign bus.O3      = head[3];

endmodule

// File: tb/tb_demux1t4_stream.sv
// Bench for demux1t4_stream: directed table on a DEPTH=2 instance, queue model on DEPTH=4.
module tb_demux1t4_stream;
    import demux_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux1t4_stream_if #(.WIDTH(8), .DEPTH(2)) bus2();
    demux1t4_stream_if #(.WIDTH(8), .DEPTH(4)) bus4();

    demux1t4_stream #(.WIDTH(8), .DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    demux1t4_stream #(.WIDTH(8), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    logic [3:0][7:0] o2, o4;
    assign o2 = {bus2.O3, bus2.O2, bus2.O1, bus2.O0};
    assign o4 = {bus4.O3, bus4.O2, bus4.O1, bus4.O0};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic            vld;
        logic [1:0]      sel;
        logic [7:0]      data;
        logic [3:0]      ordy;
        logic            exp_irdy;
        logic [3:0]      exp_ov;
        logic [7:0]      exp_cnt;
        logic [3:0][7:0] exp_o;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic vld, input logic [1:0] sel, input logic [7:0] data,
                               input logic [3:0] ordy, input logic irdy, input logic [3:0] ov,
                               input logic [7:0] cnt, input logic [31:0] o);
        vec_t r;
        r.vld = vld; r.sel = sel; r.data = data; r.ordy = ordy;
        r.exp_irdy = irdy; r.exp_ov = ov; r.exp_cnt = cnt; r.exp_o = o;
        return r;
    endfunction

    // Reference model for the DEPTH=4 instance: one queue per channel.
    logic [7:0] mq [4][$];
    logic [7:0] log3[$];
    int         maxc3 = 0;

    task automatic cyc4(output logic acc);
        logic       exp_irdy;
        logic [3:0] pops;
        #1;
        exp_irdy = (mq[bus4.S].size() < 4);
        chk("rnd irdy", bus4.I_ready, exp_irdy);
        acc = bus4.I_valid && exp_irdy;
        for (int k = 0; k < 4; k++) pops[k] = bus4.O_ready[k] && (mq[k].size() > 0);
        if (bus4.O_valid[3] && bus4.O_ready[3]) log3.push_back(o4[3]);
        @(posedge clk);
        for (int k = 0; k < 4; k++) if (pops[k]) void'(mq[k].pop_front());
        if (acc) mq[bus4.S].push_back(bus4.I);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rnd ov%0d", k), bus4.O_valid[k], mq[k].size() > 0);
            chk($sformatf("rnd cnt%0d", k), bus4.O_count[k*3 +: 3], mq[k].size());
            if (mq[k].size() > 0) chk($sformatf("rnd o%0d", k), o4[k], mq[k][0]);
        end
        if (int'(bus4.O_count[9 +: 3]) > maxc3) maxc3 = int'(bus4.O_count[9 +: 3]);
    endtask

    initial begin
        logic acc;
        int   sent;
        int   cyc;
        logic pend;

        // Test 1: reset held two cycles while I_valid=1.
        rst = 1'b1;
        bus2.I = 8'hAA; bus2.S = 2'd0; bus2.I_valid = 1'b1; bus2.O_ready = 4'h0;
        bus4.I = 8'hAA; bus4.S = 2'd0; bus4.I_valid = 1'b1; bus4.O_ready = 4'h0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst irdy2", bus2.I_ready, 0);
            chk("rst irdy4", bus4.I_ready, 0);
            chk("rst ov2", bus2.O_valid, 0);
            chk("rst ov4", bus4.O_valid, 0);
            chk("rst cnt2", bus2.O_count, 0);
            chk("rst cnt4", bus4.O_count, 0);
            chk("rst o2", o2, 0);
            chk("rst o4", o4, 0);
        end
        rst = 1'b0;
        bus2.I_valid = 1'b0; bus4.I_valid = 1'b0;
        @(posedge clk); #1;
        chk("post-rst ov2", bus2.O_valid, 0);
        chk("post-rst ov4", bus4.O_valid, 0);

        // Tests 2-4 on DEPTH=2: routing, backpressure/full, push+pop same channel.
        tbl.push_back(v(1, 0, 8'hA0, 4'hF, 1, 4'b0001, 8'h01, 32'h000000A0));
        tbl.push_back(v(1, 1, 8'hB1, 4'hF, 1, 4'b0010, 8'h04, 32'h0000B100));
        tbl.push_back(v(1, 2, 8'hC2, 4'hF, 1, 4'b0100, 8'h10, 32'h00C20000));
        tbl.push_back(v(1, 3, 8'hD3, 4'hF, 1, 4'b1000, 8'h40, 32'hD3000000));
        tbl.push_back(v(0, 3, 8'h00, 4'hF, 1, 4'b0000, 8'h00, 32'h0));
        tbl.push_back(v(1, 2, 8'h11, 4'hB, 1, 4'b0100, 8'h10, 32'h00110000));
        tbl.push_back(v(1, 2, 8'h22, 4'hB, 1, 4'b0100, 8'h20, 32'h00110000));
        tbl.push_back(v(1, 0, 8'h44, 4'hB, 1, 4'b0101, 8'h21, 32'h00110044));
        tbl.push_back(v(1, 2, 8'h33, 4'hB, 0, 4'b0100, 8'h20, 32'h00110000));
        tbl.push_back(v(1, 2, 8'h33, 4'hF, 0, 4'b0100, 8'h10, 32'h00220000));
        tbl.push_back(v(1, 2, 8'h33, 4'hF, 1, 4'b0100, 8'h10, 32'h00330000));
        tbl.push_back(v(0, 2, 8'h00, 4'hF, 1, 4'b0000, 8'h00, 32'h0));
        tbl.push_back(v(1, 1, 8'h66, 4'h0, 1, 4'b0010, 8'h04, 32'h00006600));
        tbl.push_back(v(1, 1, 8'h55, 4'h2, 1, 4'b0010, 8'h04, 32'h00005500));
        tbl.push_back(v(0, 0, 8'h00, 4'hF, 1, 4'b0000, 8'h00, 32'h0));
        foreach (tbl[i]) begin
            bus2.I_valid = tbl[i].vld; bus2.S = tbl[i].sel;
            bus2.I = tbl[i].data; bus2.O_ready = tbl[i].ordy;
            #1;
            chk($sformatf("v%0d irdy", i), bus2.I_ready, tbl[i].exp_irdy);
            @(posedge clk); #1;
            chk($sformatf("v%0d ov", i), bus2.O_valid, tbl[i].exp_ov);
            chk($sformatf("v%0d cnt", i), bus2.O_count, tbl[i].exp_cnt);
            for (int k = 0; k < 4; k++)
                if (tbl[i].exp_ov[k]) chk($sformatf("v%0d o%0d", i, k), o2[k], tbl[i].exp_o[k]);
        end

        // Test 6: reset with channels 0 and 3 partly full discards everything.
        bus2.O_ready = 4'h0; bus2.I_valid = 1'b1;
        bus2.S = 2'd0; bus2.I = 8'h01; @(posedge clk); #1;
        bus2.S = 2'd3; bus2.I = 8'h02; @(posedge clk); #1;
        bus2.S = 2'd3; bus2.I = 8'h03; @(posedge clk); #1;
        chk("mid cnt before rst", bus2.O_count, 8'h81);
        bus2.I_valid = 1'b0; rst = 1'b1; #1;
        chk("mid irdy in rst", bus2.I_ready, 0);
        @(posedge clk); #1;
        chk("mid ov after rst", bus2.O_valid, 0);
        chk("mid cnt after rst", bus2.O_count, 0);
        rst = 1'b0;
        bus2.I_valid = 1'b1; bus2.S = 2'd3; bus2.I = 8'h77;
        @(posedge clk); #1;
        bus2.I_valid = 1'b0;
        chk("mid ov 77", bus2.O_valid, 4'b1000);
        chk("mid o3 77", o2[3], 8'h77);
        chk("mid cnt 77", bus2.O_count, 8'h40);
        bus2.O_ready = 4'hF;
        @(posedge clk); #1;
        chk("mid drained", bus2.O_valid, 0);

        // Test 5: wrap-around on DEPTH=4, words 0..9 to channel 3, random consumer.
        sent = 0; cyc = 0;
        log3.delete();
        while ((sent < 10 || log3.size() < 10) && cyc < 400) begin
            bus4.I_valid = (sent < 10);
            bus4.S = 2'd3;
            bus4.I = 8'(sent);
            bus4.O_ready = 4'($urandom_range(0, 1)) << 3;
            cyc4(acc);
            if (acc) sent++;
            cyc++;
        end
        chk("wrap len", log3.size(), 10);
        for (int i = 0; i < 10; i++)
            if (i < log3.size()) chk($sformatf("wrap seq%0d", i), log3[i], i);
        chk("wrap maxcnt<=4", maxc3 <= 4, 1);

        // Fully random traffic against the queue model; unaccepted words are held.
        pend = 1'b0;
        bus4.I_valid = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!pend) begin
                bus4.I_valid = 1'($urandom_range(0, 1));
                bus4.S = 2'($urandom_range(0, 3));
                bus4.I = 8'($urandom);
            end
            bus4.O_ready = 4'($urandom);
            cyc4(acc);
            pend = bus4.I_valid && !acc;
        end
        bus4.I_valid = 1'b0;
        bus4.O_ready = 4'hF;
        repeat (6) cyc4(acc);
        chk("final empty", bus4.O_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
